// File: rtl/neopx_axis_multich.sv
// Multi-channel NeoPixel serializer fed by an AXI-Stream slave.
// A 1-entry hold register decouples the stream from the bit shifter so
// consecutive pixels go out with no gap. Each frame is locked to one channel
// and one strip type (WS2812 24-bit / SK6812 32-bit) on its first beat.
module neopx_axis_multich #(
  parameter int unsigned CLK_FREQ_HZ = 32'd72_000_000,
  parameter int unsigned NUM_CH      = 32'd4,
  parameter int unsigned DEST_W      = 32'd4,
  parameter int unsigned WS_T0H_NS   = 32'd400,
  parameter int unsigned WS_T1H_NS   = 32'd800,
  parameter int unsigned SK_T0H_NS   = 32'd300,
  parameter int unsigned SK_T1H_NS   = 32'd600,
  parameter int unsigned TBIT_NS     = 32'd1250,
  parameter int unsigned LATCH_US    = 32'd80
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic [DEST_W-1:0] s_axis_tdest,
  output logic              s_axis_tready,
  input  logic              i_sk6812,
  input  logic [7:0]        i_brightness,
  output logic [NUM_CH-1:0] o_serial,
  output logic              o_busy,
  output logic              o_underrun,
  output logic              o_drop
);

  // Round a nanosecond duration to whole clock cycles.
  function automatic logic [12:0] ns_to_cyc(input logic [63:0] ns);
    logic [63:0] t;
    t = (ns * 64'(CLK_FREQ_HZ) + 64'd500_000_000) / 64'd1_000_000_000;
    return 13'(t);
  endfunction

  localparam logic [12:0] WS_T0H    = ns_to_cyc(64'(WS_T0H_NS));
  localparam logic [12:0] WS_T1H    = ns_to_cyc(64'(WS_T1H_NS));
  localparam logic [12:0] SK_T0H    = ns_to_cyc(64'(SK_T0H_NS));
  localparam logic [12:0] SK_T1H    = ns_to_cyc(64'(SK_T1H_NS));
  localparam logic [12:0] TBIT      = ns_to_cyc(64'(TBIT_NS));
  localparam logic [12:0] LATCH_CYC = ns_to_cyc(64'(LATCH_US) * 64'd1000);

  // High time for one bit, by strip type and bit value.
  function automatic logic [12:0] t_high(input logic sk, input logic bit_v);
    logic [12:0] r;
    case ({sk, bit_v})
      2'b00:   r = WS_T0H;
      2'b01:   r = WS_T1H;
      2'b10:   r = SK_T0H;
      default: r = SK_T1H;
    endcase
    return r;
  endfunction

  // Brightness scaling: c*(b+1)>>8, so 8'hFF passes c through unchanged.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return 8'(p >> 16'd8);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [12:0]         cnt_q, cnt_d;
  logic [5:0]          bits_q, bits_d;
  logic [31:0]         sh_q, sh_d;
  logic [DEST_W-1:0]   sh_ch_q, sh_ch_d;
  logic                sh_mode_q, sh_mode_d;
  logic                sh_last_q, sh_last_d;
  logic [31:0]         hold_q, hold_d;
  logic [DEST_W-1:0]   hold_ch_q, hold_ch_d;
  logic                hold_mode_q, hold_mode_d;
  logic                hold_last_q, hold_last_d;
  logic                hold_valid_q, hold_valid_d;
  logic                tready_q, tready_d;
  logic                lock_open_q, lock_open_d;
  logic [DEST_W-1:0]   lock_ch_q, lock_ch_d;
  logic                lock_mode_q, lock_mode_d;
  logic                lock_drop_q, lock_drop_d;
  logic [NUM_CH-1:0]   serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic                drop_q, drop_d;
  logic                load_s;
  logic                accept_s;
  logic                first_s;
  logic [DEST_W-1:0]   beat_ch_s;
  logic                beat_mode_s;
  logic                beat_drop_s;

  // Stream side: frame lock, invalid-dest discard and hold-register fill.
  always_comb begin
    accept_s     = s_axis_tvalid && tready_q;
    first_s      = !lock_open_q;
    beat_ch_s    = first_s ? s_axis_tdest : lock_ch_q;
    beat_mode_s  = first_s ? i_sk6812 : lock_mode_q;
    beat_drop_s  = first_s ? (32'(s_axis_tdest) >= NUM_CH) : lock_drop_q;
    hold_d       = hold_q;
    hold_ch_d    = hold_ch_q;
    hold_mode_d  = hold_mode_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = load_s ? 1'b0 : hold_valid_q;
    lock_open_d  = lock_open_q;
    lock_ch_d    = lock_ch_q;
    lock_mode_d  = lock_mode_q;
    lock_drop_d  = lock_drop_q;
    drop_d       = 1'b0;
    if (accept_s) begin
      lock_open_d = !s_axis_tlast;
      lock_ch_d   = beat_ch_s;
      lock_mode_d = beat_mode_s;
      lock_drop_d = beat_drop_s;
      if (beat_drop_s) begin
        drop_d = s_axis_tlast;
      end else begin
        hold_valid_d = 1'b1;
        hold_d       = {scale_byte(s_axis_tdata[31:24], i_brightness),
                        scale_byte(s_axis_tdata[23:16], i_brightness),
                        scale_byte(s_axis_tdata[15:8],  i_brightness),
                        scale_byte(s_axis_tdata[7:0],   i_brightness)};
        hold_ch_d    = beat_ch_s;
        hold_mode_d  = beat_mode_s;
        hold_last_d  = s_axis_tlast;
      end
    end else begin
      drop_d = 1'b0;
    end
    tready_d = !hold_valid_d;
    busy_d   = (state_d != ST_IDLE) || hold_valid_d || (lock_open_d && !lock_drop_d);
  end

  // Bit FSM: pulse timing, shifter advance, reload from hold and latch gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    sh_d       = sh_q;
    sh_ch_d    = sh_ch_q;
    sh_mode_d  = sh_mode_q;
    sh_last_d  = sh_last_q;
    load_s     = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_s = hold_valid_q;
      end
      ST_HIGH: begin
        if (cnt_q == 13'd0) begin
          state_d = ST_LOW;
          cnt_d   = TBIT - t_high(sh_mode_q, sh_q[31]) - 13'd1;
        end else begin
          cnt_d = cnt_q - 13'd1;
        end
      end
      ST_LOW: begin
        if (cnt_q != 13'd0) begin
          cnt_d = cnt_q - 13'd1;
        end else if (bits_q > 6'd1) begin
          state_d = ST_HIGH;
          sh_d    = {sh_q[30:0], 1'b0};
          bits_d  = bits_q - 6'd1;
          cnt_d   = t_high(sh_mode_q, sh_q[30]) - 13'd1;
        end else if (sh_last_q) begin
          state_d = ST_LATCH;
          cnt_d   = LATCH_CYC - 13'd1;
        end else if (hold_valid_q) begin
          load_s = 1'b1;
        end else begin
          underrun_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (cnt_q == 13'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 13'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A reload starts the first bit of the held pixel in the same cycle.
    if (load_s) begin
      state_d   = ST_HIGH;
      sh_d      = hold_q;
      sh_ch_d   = hold_ch_q;
      sh_mode_d = hold_mode_q;
      sh_last_d = hold_last_q;
      bits_d    = hold_mode_q ? 6'd32 : 6'd24;
      cnt_d     = t_high(hold_mode_q, hold_q[31]) - 13'd1;
    end else begin
      sh_mode_d = sh_mode_d;
    end
    serial_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      serial_d[i] = (state_d == ST_HIGH) && (sh_ch_d == DEST_W'(i));
    end
  end

  // State and output registers; reset drops every line at once.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 13'd0;
      bits_q       <= 6'd0;
      sh_q         <= 32'd0;
      sh_ch_q      <= '0;
      sh_mode_q    <= 1'b0;
      sh_last_q    <= 1'b0;
      hold_q       <= 32'd0;
      hold_ch_q    <= '0;
      hold_mode_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      tready_q     <= 1'b0;
      lock_open_q  <= 1'b0;
      lock_ch_q    <= '0;
      lock_mode_q  <= 1'b0;
      lock_drop_q  <= 1'b0;
      serial_q     <= '0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      sh_q         <= sh_d;
      sh_ch_q      <= sh_ch_d;
      sh_mode_q    <= sh_mode_d;
      sh_last_q    <= sh_last_d;
      hold_q       <= hold_d;
      hold_ch_q    <= hold_ch_d;
      hold_mode_q  <= hold_mode_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      tready_q     <= tready_d;
      lock_open_q  <= lock_open_d;
      lock_ch_q    <= lock_ch_d;
      lock_mode_q  <= lock_mode_d;
      lock_drop_q  <= lock_drop_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      drop_q       <= drop_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_serial      = serial_q;
  assign o_busy        = busy_q;
  assign o_underrun    = underrun_q;
  assign o_drop        = drop_q;

endmodule
